sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side responder for the EXE/MEM pipeline register. It accepts a 32-bit load or store request (`rd_en`/`wr_en`, `address`, `write_data`) and performs it on an external 16-bit-wide SRAM as two half-word accesses. It drives `ready` low to freeze the pipeline until the access completes, then returns load data on `read_data`.

## Interface
- `WAIT_CYCLES`, default 6: total cycles from request acceptance to the `ready` pulse; legal range 3..15.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rd_en`  in  1  load request from MEM stage.
- `wr_en`  in  1  store request from MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  last completed load word.
- `ready`  out  1  high = no access pending or access done this cycle; low = freeze pipeline.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_dq_out`  out  16  SRAM write data.
- `sram_dq_oe`  out  1  tri-state enable for `sram_dq_out`.
- `sram_dq_in`  in  16  SRAM read data; the SRAM is combinational, valid in the same cycle as `sram_addr`.

## Operation
- States: IDLE, LO, HI, WAIT, DONE. A 4-bit cycle counter runs from acceptance.
- IDLE behaviour:
  - When `rd_en|wr_en` is sampled high, latch the op, `address` and `write_data`, clear the counter, and go to LO.
  - If both enables are high, the request is a store.
- Address mapping:
  - `word = (address - BASE_ADDR) >> 2`, computed in 32-bit modulo arithmetic; only bits [16:0] are kept.
  - `sram_addr = {word[16:0], half}`, where `half` is 0 in LO and 1 in HI. In other states, `sram_addr` holds its last value (0 after reset).
- LO state:
  - Store: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out=write_data[15:0]`.
  - Load: capture `sram_dq_in` into a low-half register at the clock edge.
  - Next state is HI.
- HI state:
  - Store: same as LO using `write_data[31:16]`.
  - Load: `read_data <= {sram_dq_in, low_half}` at the clock edge.
  - Next state is WAIT, or DONE if `WAIT_CYCLES==3`.
- WAIT: SRAM idle (`we_n=1`, `oe=0`). Stay until the counter reaches `WAIT_CYCLES-1`, then go to DONE.
- DONE: `ready=1` for exactly one cycle, then return to IDLE unconditionally. No new request is accepted in DONE.
- `ready` (combinational):
  - 1 in DONE.
  - 1 in IDLE when `rd_en|wr_en` is low.
  - 0 otherwise, including the IDLE acceptance cycle.
- Latched values govern the whole transaction. Input changes or enable deassertion mid-transaction are ignored, and the transaction still completes with a DONE pulse.
- Stores never modify `read_data`. `read_data` holds its value until the next load completes.

## Timing
- Reset values: state=IDLE, counter=0, `read_data=0`, `sram_addr=0`, `sram_we_n=1`, `sram_dq_oe=0`, `sram_dq_out=0`, low-half register=0. `ready` is 1 if no request is present.
- Reset asserted mid-transaction: immediate return to IDLE; `we_n` and `oe` deassert in the same instant; no DONE pulse; `read_data` is cleared.
- Cycle sequence from the acceptance cycle 0 (IDLE, request high):
  - Cycle 1: LO.
  - Cycle 2: HI.
  - Cycles 3..`WAIT_CYCLES-1`: WAIT.
  - Cycle `WAIT_CYCLES`: DONE, `ready=1`.
- `read_data` is valid from cycle 3 onward, and therefore in the DONE cycle.
- `sram_we_n` is low only in cycles 1 and 2 of a store, with address and data stable for the whole cycle.
- Back-to-back requests: the pipeline advances at the DONE edge. The next request is sampled in the following IDLE cycle, giving a period of `WAIT_CYCLES+1` cycles per access.
- Counter width 4 bits; `WAIT_CYCLES` above 15 is illegal.

## Test plan
- Store 0xDEADBEEF at address 1032, then load from 1032:
  - Store: `sram_addr` 4 then 5, `dq_out` 0xBEEF then 0xDEAD, `we_n` low for exactly 2 cycles.
  - Load: returns 0xDEADBEEF.
- Latency with `WAIT_CYCLES=6`: load request at cycle 0 -> `ready` low in cycles 0–5, high in cycle 6 only, and high again in cycle 7 if the enables have dropped.
- Back-to-back stores to 1024 and 1028, with enables held high through DONE -> second access starts in cycle 8 at `sram_addr` 2; both `ready` pulses are one cycle wide.
- `rd_en` and `wr_en` both high, `address`=1024, `write_data`=0x12345678 -> behaves as a store; `read_data` unchanged.
- Change `address` and `write_data` in cycle 1 of a store -> SRAM still sees the cycle-0 values.
- Assert `rst` in a cycle-2 HI store -> `we_n`=1 and `oe`=0 immediately, `read_data`=0, no `ready` pulse. A load requested after reset completes normally in 6 cycles.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: 32-bit load/store responder that splits each access into two
// half-word cycles on a 16-bit SRAM and stalls the pipeline via o_ready.
module sram_controller #(
    parameter int          WAIT_CYCLES = 6,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic [17:0] o_sram_addr,
    output logic        o_sram_we_n,
    output logic [15:0] o_sram_dq_out,
    output logic        o_sram_dq_oe,
    input  logic [15:0] i_sram_dq_in
);
    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_DONE} state_t;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [16:0] r_word;
    logic [15:0] r_wd_hi;
    logic [15:0] r_lo;
    logic        w_req;
    logic [16:0] w_word;
    assign w_req   = i_rd_en | i_wr_en;
    assign w_word  = 17'((i_address - BASE_ADDR) >> 2);
    assign o_ready = (r_state == S_DONE) || (r_state == S_IDLE && !w_req);
    // SRAM pins are registered one state ahead so they are stable for the whole LO/HI cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_wr          <= 1'b0;
            r_word        <= 17'd0;
            r_wd_hi       <= 16'd0;
            r_lo          <= 16'd0;
            o_read_data   <= 32'd0;
            o_sram_addr   <= 18'd0;
            o_sram_we_n   <= 1'b1;
            o_sram_dq_out <= 16'd0;
            o_sram_dq_oe  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_state      <= S_LO;
                    r_cnt        <= 4'd0;
                    r_wr         <= i_wr_en;
                    r_word       <= w_word;
                    r_wd_hi      <= i_write_data[31:16];
                    o_sram_addr  <= {w_word, 1'b0};
                    o_sram_we_n  <= ~i_wr_en;
                    o_sram_dq_oe <= i_wr_en;
                    if (i_wr_en) o_sram_dq_out <= i_write_data[15:0];
                end
                S_LO: begin
                    r_state     <= S_HI;
                    r_cnt       <= r_cnt + 4'd1;
                    o_sram_addr <= {r_word, 1'b1};
                    if (r_wr) o_sram_dq_out <= r_wd_hi;
                    else r_lo <= i_sram_dq_in;
                end
                S_HI: begin
                    r_state      <= (WAIT_CYCLES == 3) ? S_DONE : S_WAIT;
                    r_cnt        <= r_cnt + 4'd1;
                    o_sram_we_n  <= 1'b1;
                    o_sram_dq_oe <= 1'b0;
                    if (!r_wr) o_read_data <= {i_sram_dq_in, r_lo};
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(WAIT_CYCLES - 2)) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed stimulus against a transaction-level model of the
// controller plus a behavioural SRAM, with a per-cycle compare on the falling edge.
module tb_sram_controller;
    localparam int W = 6;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_we_n, sram_dq_oe;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    int vecs = 0;
    int errs = 0;

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_wr_en(wr_en),
        .i_address(address), .i_write_data(write_data), .o_read_data(read_data),
        .o_ready(ready), .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n),
        .o_sram_dq_out(sram_dq_out), .o_sram_dq_oe(sram_dq_oe), .i_sram_dq_in(sram_dq_in)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write on the clock edge while we_n is low
    logic [15:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    assign sram_dq_in = mem[sram_addr[7:0]];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: cycle index within the current access, plus a word memory
    logic [31:0] mmem [int];
    int          k = -1;
    logic        m_wr;
    logic [16:0] m_word;
    logic [31:0] m_data;
    logic [17:0] e_addr = 18'd0;
    logic [31:0] e_rd = 32'd0;

    function automatic logic [31:0] get_word(input logic [16:0] w);
        logic [17:0] a0, a1;
        a0 = {w, 1'b0};
        a1 = {w, 1'b1};
        if (mmem.exists(int'(w))) return mmem[int'(w)];
        return {16'hA000 | {8'h00, a1[7:0]}, 16'hA000 | {8'h00, a0[7:0]}};
    endfunction

    always @(negedge clk) begin
        int   cur;
        logic st;
        if (rst) begin
            chk("rst_ready", 32'(ready), 32'(!(rd_en || wr_en)));
            chk("rst_we_n", 32'(sram_we_n), 32'd1);
            chk("rst_oe", 32'(sram_dq_oe), 32'd0);
            chk("rst_read_data", read_data, 32'd0);
            chk("rst_addr", 32'(sram_addr), 32'd0);
            k = -1;
            e_addr = 18'd0;
            e_rd = 32'd0;
        end else begin
            cur = k;
            if (cur < 0 && (rd_en || wr_en)) begin
                cur = 0;
                m_wr = wr_en;
                m_word = 17'((address - 32'd1024) >> 2);
                m_data = write_data;
            end
            st = m_wr && (cur == 1 || cur == 2);
            if (cur == 1) e_addr = {m_word, 1'b0};
            else if (cur == 2) e_addr = {m_word, 1'b1};
            chk("m_ready", 32'(ready), 32'(cur < 0 || cur == W));
            chk("m_addr", 32'(sram_addr), 32'(e_addr));
            chk("m_we_n", 32'(sram_we_n), 32'(!st));
            chk("m_oe", 32'(sram_dq_oe), 32'(st));
            if (st) chk("m_dq_out", 32'(sram_dq_out), 32'(cur == 1 ? m_data[15:0] : m_data[31:16]));
            chk("m_read_data", read_data, e_rd);
            if (cur == 2 && !m_wr) e_rd = get_word(m_word);
            if (cur == W && m_wr) mmem[int'(m_word)] = m_data;
            k = (cur < 0 || cur == W) ? -1 : cur + 1;
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rd_en = r;
        wr_en = w;
        address = a;
        write_data = d;
    endtask

    task automatic negs(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = 32'd0;
        write_data = 32'd0;
        @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        chk("reset_read_data", read_data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        // Store 0xDEADBEEF at 1032; inputs change in cycle 1 and must be ignored
        drive(0, 1, 32'd1032, 32'hDEADBEEF);
        negs(1); chk("st_c0_ready", 32'(ready), 32'd0);
        drive(0, 0, 32'd2000, 32'h0);
        negs(1); chk("st_c1_addr", 32'(sram_addr), 32'd4);
        chk("st_c1_dq", 32'(sram_dq_out), 32'hBEEF);
        chk("st_c1_we_n", 32'(sram_we_n), 32'd0);
        negs(1); chk("st_c2_addr", 32'(sram_addr), 32'd5);
        chk("st_c2_dq", 32'(sram_dq_out), 32'hDEAD);
        chk("st_c2_we_n", 32'(sram_we_n), 32'd0);
        negs(1); chk("st_c3_we_n", 32'(sram_we_n), 32'd1);
        negs(3); chk("st_c6_ready", 32'(ready), 32'd1);
        negs(1); chk("st_c7_ready", 32'(ready), 32'd1);
        // Load back from 1032, latency check
        drive(1, 0, 32'd1032, 32'h0);
        negs(1); chk("ld_c0_ready", 32'(ready), 32'd0);
        drive(0, 0, 32'h0, 32'h0);
        for (int i = 1; i < W; i++) begin
            negs(1); chk("ld_busy_ready", 32'(ready), 32'd0);
        end
        negs(1); chk("ld_c6_ready", 32'(ready), 32'd1);
        chk("ld_c6_data", read_data, 32'hDEADBEEF);
        negs(1); chk("ld_c7_ready", 32'(ready), 32'd1);
        // Back-to-back stores with the enable held through DONE
        drive(0, 1, 32'd1024, 32'h11112222);
        negs(7); chk("b2b_c6_ready", 32'(ready), 32'd1);
        drive(0, 1, 32'd1028, 32'h33334444);
        negs(1); chk("b2b_c7_ready", 32'(ready), 32'd0);
        drive(0, 0, 32'h0, 32'h0);
        negs(1); chk("b2b_c8_addr", 32'(sram_addr), 32'd2);
        chk("b2b_c8_dq", 32'(sram_dq_out), 32'h4444);
        negs(4); chk("b2b_c12_ready", 32'(ready), 32'd0);
        negs(1); chk("b2b_c13_ready", 32'(ready), 32'd1);
        negs(1); chk("b2b_c14_ready", 32'(ready), 32'd1);
        // Both enables high behaves as a store and leaves read_data alone
        drive(1, 1, 32'd1024, 32'h12345678);
        negs(1);
        drive(0, 0, 32'h0, 32'h0);
        negs(1); chk("both_c1_we_n", 32'(sram_we_n), 32'd0);
        chk("both_c1_dq", 32'(sram_dq_out), 32'h5678);
        negs(5); chk("both_c6_ready", 32'(ready), 32'd1);
        chk("both_read_data", read_data, 32'hDEADBEEF);
        negs(1);
        // Reset during the HI cycle of a store
        drive(0, 1, 32'd1040, 32'hCAFEF00D);
        negs(1);
        drive(0, 0, 32'h0, 32'h0);
        negs(2); chk("rst_hi_we_n_before", 32'(sram_we_n), 32'd0);
        chk("rst_hi_addr", 32'(sram_addr), 32'd9);
        #1 rst = 1'b1;
        #1;
        chk("rst_hi_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_hi_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_hi_read_data", read_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        // Load after reset completes normally
        drive(1, 0, 32'd1032, 32'h0);
        negs(1); chk("pr_c0_ready", 32'(ready), 32'd0);
        drive(0, 0, 32'h0, 32'h0);
        for (int i = 1; i < W; i++) begin
            negs(1); chk("pr_busy_ready", 32'(ready), 32'd0);
        end
        negs(1); chk("pr_c6_ready", 32'(ready), 32'd1);
        chk("pr_c6_data", read_data, 32'hDEADBEEF);
        // Address below BASE_ADDR wraps modulo 2^32 and keeps word bits [16:0]
        drive(1, 0, 32'd1020, 32'h0);
        negs(1);
        drive(0, 0, 32'h0, 32'h0);
        negs(1); chk("wrap_c1_addr", 32'(sram_addr), 32'h3FFFE);
        negs(1); chk("wrap_c2_addr", 32'(sram_addr), 32'h3FFFF);
        negs(4); chk("wrap_c6_data", read_data, 32'hA0FFA0FE);
        negs(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
